// File: rtl/intern_sync_multi_if.sv
// Handshake bundle between reconfiguration controller, cores and the
// safe-state synchroniser; one bit per channel on every signal.
interface intern_sync_multi_if #(
  parameter int NUM_CH = 1
);
  logic [NUM_CH-1:0] rc_is_idle;
  logic [NUM_CH-1:0] rc_reqn;
  logic [NUM_CH-1:0] rc_ackn;
  logic [NUM_CH-1:0] rc_quiesce;
  logic [NUM_CH-1:0] rc_timeout;

  modport master (
    output rc_is_idle,
    output rc_reqn,
    input  rc_ackn,
    input  rc_quiesce,
    input  rc_timeout
  );

  modport slave (
    input  rc_is_idle,
    input  rc_reqn,
    output rc_ackn,
    output rc_quiesce,
    output rc_timeout
  );
endinterface

// File: rtl/intern_sync_multi.sv
// Multi-channel reconfiguration safe-state synchroniser (Mealy ack).
// Optional request timeout enabled by INTERN_SYNC_TIMEOUT_EN.
module intern_sync_multi #(
  parameter int NUM_CH      = 1,
  parameter int QUAL_CYC    = 1,
  parameter int TIMEOUT_CYC = 1024,
  parameter int TIMEOUT_W   = 16
) (
  input logic                clk,
  input logic                rst,
  intern_sync_multi_if.slave bus
);
  localparam int QW = $clog2(QUAL_CYC) + 1;
  localparam logic [QW-1:0] QMAX = QW'(QUAL_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WREL = 2'd2
  } st_e;

  logic [NUM_CH-1:0] ack_v;
  logic [NUM_CH-1:0] qui_v;
  logic [NUM_CH-1:0] tmo_v;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    st_e           st_q, st_d;
    logic [QW-1:0] qual_q, qual_d;
    logic          reqn, idle;
    logic          ack, tmo, qui;
    logic          tmo_hit;

    assign reqn = bus.rc_reqn[c];
    assign idle = bus.rc_is_idle[c];

`ifdef INTERN_SYNC_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TMAX =
      TIMEOUT_W'(TIMEOUT_CYC - 1);
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;

    assign tmo_hit = (tmo_q == TMAX);

    // Counts only REQ cycles that stay in REQ
    always_comb begin
      tmo_d = tmo_q;
      if (st_q == IDLE)
        tmo_d = '0;
      else if (st_q == REQ && st_d == REQ)
        tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge clk) begin
      if (rst) tmo_q <= '0;
      else     tmo_q <= tmo_d;
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_W'(TIMEOUT_CYC - 1);
    assign tmo_hit    = 1'b0;
`endif

    always_comb begin
      st_d   = st_q;
      qual_d = idle ? qual_q : '0;
      ack    = 1'b0;
      tmo    = 1'b0;
      qui    = 1'b0;
      case (st_q)
        IDLE: begin
          if (!reqn) begin
            st_d   = REQ;
            qual_d = '0;
          end
        end
        REQ: begin
          qui = ~reqn;
          if (idle && qual_q != QMAX)
            qual_d = qual_q + 1'b1;
          // Abort beats ack, ack beats timeout
          if (reqn) begin
            st_d = IDLE;
          end else if (idle && qual_q == QMAX) begin
            ack  = 1'b1;
            st_d = WREL;
          end else if (tmo_hit) begin
            tmo  = 1'b1;
            st_d = WREL;
          end
        end
        WREL: begin
          if (reqn) st_d = IDLE;
        end
        default: st_d = IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        st_q   <= IDLE;
        qual_q <= '0;
      end else begin
        st_q   <= st_d;
        qual_q <= qual_d;
      end
    end

    assign ack_v[c] = ack;
    assign qui_v[c] = qui;
    assign tmo_v[c] = tmo;
  end

  assign bus.rc_ackn    = ~(ack_v & {NUM_CH{~rst}});
  assign bus.rc_quiesce = qui_v & {NUM_CH{~rst}};
  assign bus.rc_timeout = tmo_v & {NUM_CH{~rst}};
endmodule

// File: tb/tb_intern_sync_multi.sv
// Directed bench: a 4-channel QUAL_CYC=1 instance and a 1-channel
// QUAL_CYC=3 instance, both with TIMEOUT_CYC=8.
module tb_intern_sync_multi;
  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] reqA = 4'b1111;
  logic [3:0] idleA = 4'b0000;
  logic       reqB = 1'b1;
  logic       idleB = 1'b0;

  int vecs = 0;
  int miss = 0;

  intern_sync_multi_if #(.NUM_CH(4)) ifA ();
  intern_sync_multi_if #(.NUM_CH(1)) ifB ();

  assign ifA.rc_reqn    = reqA;
  assign ifA.rc_is_idle = idleA;
  assign ifB.rc_reqn    = reqB;
  assign ifB.rc_is_idle = idleB;

  intern_sync_multi #(
    .NUM_CH(4), .QUAL_CYC(1), .TIMEOUT_CYC(TMO), .TIMEOUT_W(16)
  ) dA (
    .clk(clk), .rst(rst), .bus(ifA)
  );

  intern_sync_multi #(
    .NUM_CH(1), .QUAL_CYC(3), .TIMEOUT_CYC(TMO), .TIMEOUT_W(16)
  ) dB (
    .clk(clk), .rst(rst), .bus(ifB)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Model: phase 0=idle, 1=requesting, 2=waiting release.
  // run = consecutive idle cycles seen in the request, n = request cycle no.
  int ph  [5] = '{default: 0};
  int run [5] = '{default: 0};
  int n   [5] = '{default: 0};

  function automatic int qof(int i);
    return (i == 4) ? 3 : 1;
  endfunction

  always @(negedge clk) begin
    logic [4:0] rq, id, eA, eQ, eT, eN, aN, aQ, aT;
    int rn;
    rq = {reqB, reqA};
    id = {idleB, idleA};
    eA = '0;
    eQ = '0;
    eT = '0;
    for (int i = 0; i < 5; i++) begin
      rn = 0;
      if (ph[i] == 1) begin
        rn = id[i] ? run[i] + 1 : 0;
        if (!rst && !rq[i]) begin
          eQ[i] = 1'b1;
          eA[i] = (rn >= qof(i));
`ifdef INTERN_SYNC_TIMEOUT_EN
          eT[i] = !eA[i] && (n[i] == TMO);
`endif
        end
      end
      if (rst) begin
        ph[i] = 0;
      end else begin
        case (ph[i])
          0: if (!rq[i]) begin ph[i] = 1; run[i] = 0; n[i] = 1; end
          1: begin
            if (rq[i]) ph[i] = 0;
            else if (eA[i] || eT[i]) ph[i] = 2;
            else begin run[i] = rn; n[i] = n[i] + 1; end
          end
          default: if (rq[i]) ph[i] = 0;
        endcase
      end
    end
    eN = ~eA;
    aN = {ifB.rc_ackn, ifA.rc_ackn};
    aQ = {ifB.rc_quiesce, ifA.rc_quiesce};
    aT = {ifB.rc_timeout, ifA.rc_timeout};
    chk("model_ackn", aN, eN);
    chk("model_quiesce", aQ, eQ);
    chk("model_timeout", aT, eT);
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    nxt();
    #1;
    chk("rst_ackn", ifA.rc_ackn, 4'b1111);
    chk("rst_quiesce", ifA.rc_quiesce, 4'b0000);
    nxt();
    rst = 1'b0;
    #1;
    chk("post_rst_ackn", ifA.rc_ackn, 4'b1111);
    chk("post_rst_ackn_b", ifB.rc_ackn, 1'b1);

    // QUAL_CYC=1 basic handshake on ch0
    nxt(); reqA[0] = 1'b0;
    #1 chk("t1_c2_quiesce", ifA.rc_quiesce, 4'b0000);
    nxt();
    #1 chk("t1_c3_quiesce", ifA.rc_quiesce, 4'b0001);
    chk("t1_c3_ackn", ifA.rc_ackn, 4'b1111);
    nxt(); nxt();
    nxt(); idleA[0] = 1'b1;
    #1 chk("t1_c6_ackn", ifA.rc_ackn, 4'b1110);
    chk("t1_c6_quiesce", ifA.rc_quiesce, 4'b0001);
    nxt();
    #1 chk("t1_c7_ackn", ifA.rc_ackn, 4'b1111);
    chk("t1_c7_quiesce", ifA.rc_quiesce, 4'b0000);
    nxt(); reqA[0] = 1'b1; idleA[0] = 1'b0;
    nxt();

    // QUAL_CYC=3 with idle pattern 1,1,0,1,1,1
    nxt(); reqB = 1'b0;
    begin
      logic [5:0] pat;
      pat = 6'b111011;
      for (int k = 0; k < 6; k++) begin
        nxt(); idleB = pat[k];
        #1 chk("q3_ackn", ifB.rc_ackn, (k == 5) ? 1'b0 : 1'b1);
        chk("q3_quiesce", ifB.rc_quiesce, 1'b1);
      end
    end
    nxt();
    #1 chk("q3_after_ackn", ifB.rc_ackn, 1'b1);
    nxt(); reqB = 1'b1; idleB = 1'b0;
    nxt();

    // Timeout on ch1 (or indefinite wait without the feature)
    nxt(); reqA[1] = 1'b0;
    for (int k = 1; k <= TMO + 3; k++) begin
      nxt();
`ifdef INTERN_SYNC_TIMEOUT_EN
      #1 chk("tmo_pulse", ifA.rc_timeout, (k == TMO) ? 4'b0010 : 4'b0000);
      chk("tmo_quiesce", ifA.rc_quiesce, (k <= TMO) ? 4'b0010 : 4'b0000);
`else
      #1 chk("tmo_off", ifA.rc_timeout, 4'b0000);
      chk("tmo_off_quiesce", ifA.rc_quiesce, 4'b0010);
`endif
      chk("tmo_ackn", ifA.rc_ackn, 4'b1111);
    end
    nxt(); reqA[1] = 1'b1;
    nxt();

    // Abort after 3 low cycles
    nxt(); reqA[0] = 1'b0;
    nxt(); nxt();
    nxt(); reqA[0] = 1'b1;
    #1 chk("abort_quiesce", ifA.rc_quiesce, 4'b0000);
    chk("abort_ackn", ifA.rc_ackn, 4'b1111);
    nxt();
    #1 chk("abort_quiesce2", ifA.rc_quiesce, 4'b0000);

    // Abort and ack condition together: abort wins
    nxt(); reqA[0] = 1'b0;
    nxt();
    nxt(); reqA[0] = 1'b1; idleA[0] = 1'b1;
    #1 chk("abort_vs_ack", ifA.rc_ackn, 4'b1111);
    nxt(); idleA[0] = 1'b0;
    nxt();

    // Staggered requests on ch0 and ch2, ch2 idles first
    nxt(); reqA[0] = 1'b0;
    nxt(); reqA[2] = 1'b0;
    nxt(); idleA[2] = 1'b1;
    #1 chk("stag_ack2", ifA.rc_ackn, 4'b1011);
    nxt(); idleA[0] = 1'b1;
    #1 chk("stag_ack0", ifA.rc_ackn, 4'b1110);
    chk("stag_quiesce", ifA.rc_quiesce, 4'b0001);
    nxt(); reqA = 4'b1111; idleA = 4'b0000;
    #1 chk("stag_done", ifA.rc_ackn, 4'b1111);
    nxt();

    // Reset mid-request with idle high
    nxt(); reqA[0] = 1'b0;
    nxt();
    #1 chk("rmid_quiesce", ifA.rc_quiesce, 4'b0001);
    nxt(); rst = 1'b1; idleA[0] = 1'b1;
    #1 chk("rmid_rst_ackn", ifA.rc_ackn, 4'b1111);
    chk("rmid_rst_quiesce", ifA.rc_quiesce, 4'b0000);
    nxt(); rst = 1'b0;
    #1 chk("rmid_idle_ackn", ifA.rc_ackn, 4'b1111);
    nxt();
    #1 chk("rmid_fresh_ack", ifA.rc_ackn, 4'b1110);
    nxt(); reqA[0] = 1'b1; idleA[0] = 1'b0;
    nxt();
    nxt();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
